// File: rtl/bp_profiler_snapshot_streamer_pkg.sv
// Shared types and framing constants for the profiler snapshot streamer.
package bp_profiler_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_hdr,
    e_stream
  } bp_prof_stream_state_e;

  localparam logic [7:0] prof_frame_magic_gp = 8'hA5;

  // Frame header: sequence number, frame length, magic byte.
  function automatic logic [31:0] prof_frame_header(input logic [15:0] seq,
                                                    input logic [7:0]  els);
    return {seq, els, prof_frame_magic_gp};
  endfunction

endpackage

// File: rtl/bp_profiler_snapshot_streamer_if.sv
// Valid/ready stream link carrying framed snapshot words toward the host.
interface bp_profiler_snapshot_streamer_if #(
  parameter int unsigned width_p = 32
);
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               last_o;
  logic               ready_i;

  modport master (output data_o, output v_o, output last_o, input ready_i);
  modport slave  (input data_o, input v_o, input last_o, output ready_i);
endinterface

// File: rtl/bp_profiler_snapshot_streamer_timer.sv
// Periodic trigger source: pulses tick_o once every interval_i enabled cycles.
module bp_profiler_interval_timer #(
  parameter int unsigned interval_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic [interval_width_p-1:0] interval_i,
  output logic                        tick_o
);

  logic [interval_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    tick_o = 1'b0;
    if (en_i && (interval_i != '0)) begin
      // >= keeps the timer wrapping if interval_i shrinks below the running count
      if (cnt_q >= interval_i - interval_width_p'(1)) begin
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + interval_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bp_profiler_snapshot_streamer.sv
// Captures the profiler counter array into a shadow bank on trigger and streams
// it as a header-prefixed frame over a valid/ready link.
module bp_profiler_snapshot_streamer
  import bp_profiler_pkg::*;
#(
  parameter int unsigned width_p          = 32,
  parameter int unsigned els_p            = 56,
  parameter int unsigned interval_width_p = 32,
  parameter int unsigned ovr_width_p      = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  input  logic                           trigger_i,
  input  logic [interval_width_p-1:0]    interval_i,
  input  logic [els_p-1:0][width_p-1:0]  counters_i,
  bp_profiler_snapshot_streamer_if.master stream_o,
  output logic                           busy_o,
  output logic [15:0]                    seq_o,
  output logic [ovr_width_p-1:0]         overrun_o
);

  localparam int unsigned idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  bp_prof_stream_state_e       state_q, state_d;
  logic [idx_w_lp-1:0]         idx_q, idx_d;
  logic [15:0]                 seq_q, seq_d;
  logic [ovr_width_p-1:0]      ovr_q, ovr_d;
  logic [els_p-1:0][width_p-1:0] shadow_q;

  logic               tick, trig, capture, valid, last;
  logic [width_p-1:0] word;

  bp_profiler_interval_timer #(
    .interval_width_p(interval_width_p)
  ) timer_u (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .interval_i(interval_i),
    .tick_o    (tick)
  );

  assign trig  = en_i & (trigger_i | tick);
  assign valid = (state_q != e_idle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    capture = 1'b0;
    word    = '0;
    last    = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (trig) begin
          capture = 1'b1;
          state_d = e_hdr;
        end
      end
      e_hdr: begin
        word = width_p'(prof_frame_header(seq_q, 8'(els_p)));
        if (stream_o.ready_i) begin
          idx_d   = '0;
          state_d = e_stream;
        end
      end
      e_stream: begin
        word = shadow_q[idx_q];
        last = (idx_q == idx_w_lp'(els_p - 1));
        if (stream_o.ready_i) begin
          if (last) begin
            state_d = e_idle;
            seq_d   = seq_q + 16'd1;
          end else begin
            idx_d = idx_q + idx_w_lp'(1);
          end
        end
      end
      default: state_d = e_idle;
    endcase
    // Triggers landing while a frame is in flight, including its final beat, are dropped.
    if (trig && valid && (ovr_q != '1)) ovr_d = ovr_q + ovr_width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      idx_q    <= '0;
      seq_q    <= '0;
      ovr_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      if (capture) shadow_q <= counters_i;
    end
  end

  assign stream_o.v_o    = valid;
  assign stream_o.data_o = word;
  assign stream_o.last_o = last;
  assign busy_o          = valid;
  assign seq_o           = seq_q;
  assign overrun_o       = ovr_q;

endmodule
